// File: rtl/ecg_rr_analyzer.sv
// R-peak detector with RR-interval measurement, valid/ready interval output,
// running mean over the last AVG_DEPTH intervals and asystole/overrun flags.
module ecg_rr_analyzer #(
  parameter int DATA_W    = 16,
  parameter int RR_W      = 16,
  parameter int REFRACT   = 200,
  parameter int AVG_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] ecg_sample,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     peak_detected,
  output logic [RR_W-1:0]          rr_interval,
  output logic                     rr_valid,
  input  logic                     rr_ready,
  output logic [RR_W-1:0]          rr_avg,
  output logic                     avg_valid,
  output logic                     asystole,
  output logic                     overrun
);

  localparam int AVG_SH = $clog2(AVG_DEPTH);
  localparam int ACC_W  = RR_W + AVG_SH;
  localparam int REF_W  = $clog2(REFRACT + 1);
  localparam int CNT_W  = AVG_SH + 1;
  localparam logic [RR_W-1:0]  RR_MAX     = {RR_W{1'b1}};
  localparam logic [REF_W-1:0] REFR_LOAD  = REF_W'(REFRACT - 1);
  localparam logic [CNT_W-1:0] AVG_FULL   = CNT_W'(AVG_DEPTH);
  localparam logic [CNT_W-1:0] AVG_LAST   = CNT_W'(AVG_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_WARMUP,
    ST_REFRACT_1ST,
    ST_REFRACT,
    ST_ARMED
  } state_t;

  state_t state_q, state_d;

  // s2_q/s1_q are the two previous samples; the incoming sample acts as s0.
  logic signed [DATA_W-1:0] s2_q, s2_d, s1_q, s1_d;
  logic [1:0]               fill_q, fill_d;
  logic [RR_W-1:0]          rr_cnt_q, rr_cnt_d;
  logic [REF_W-1:0]         refr_cnt_q, refr_cnt_d;
  logic                     peak_q, peak_d;
  logic [RR_W-1:0]          rr_interval_q, rr_interval_d;
  logic                     rr_valid_q, rr_valid_d;
  logic                     overrun_q, overrun_d;
  logic                     push_q, push_d;
  logic [AVG_SH-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         avg_cnt_q, avg_cnt_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic                     avg_valid_q, avg_valid_d;
  logic [RR_W-1:0]          buf_q [AVG_DEPTH];
  logic [RR_W-1:0]          buf_d [AVG_DEPTH];

  logic            candidate;
  logic [RR_W-1:0] rr_inc;

  assign candidate = (fill_q == 2'd2) && (s1_q > threshold) &&
                     (s1_q >= s2_q) && (s1_q > ecg_sample);
  assign rr_inc    = (rr_cnt_q == RR_MAX) ? rr_cnt_q : rr_cnt_q + RR_W'(1);

  always_comb begin
    state_d       = state_q;
    s2_d          = s2_q;
    s1_d          = s1_q;
    fill_d        = fill_q;
    rr_cnt_d      = rr_cnt_q;
    refr_cnt_d    = refr_cnt_q;
    peak_d        = 1'b0;
    rr_interval_d = rr_interval_q;
    rr_valid_d    = rr_valid_q;
    overrun_d     = overrun_q;
    push_d        = 1'b0;

    if (rr_valid_q && rr_ready) begin
      rr_valid_d = 1'b0;
    end

    if (sample_valid) begin
      s2_d = s1_q;
      s1_d = ecg_sample;
      if (fill_q != 2'd2) begin
        fill_d = fill_q + 2'd1;
      end

      unique case (state_q)
        ST_WARMUP: begin
          if (candidate) begin
            peak_d     = 1'b1;
            rr_cnt_d   = '0;
            refr_cnt_d = REFR_LOAD;
            state_d    = ST_REFRACT_1ST;
          end
        end
        ST_REFRACT_1ST, ST_REFRACT: begin
          rr_cnt_d = rr_inc;
          if (refr_cnt_q == '0) begin
            state_d = ST_ARMED;
          end else begin
            refr_cnt_d = refr_cnt_q - REF_W'(1);
          end
        end
        ST_ARMED: begin
          if (candidate) begin
            peak_d        = 1'b1;
            rr_interval_d = rr_inc;
            rr_valid_d    = 1'b1;
            push_d        = 1'b1;
            // Overwriting an interval the consumer never took is recorded.
            if (rr_valid_q && !rr_ready) begin
              overrun_d = 1'b1;
            end
            rr_cnt_d   = '0;
            refr_cnt_d = REFR_LOAD;
            state_d    = ST_REFRACT;
          end else begin
            rr_cnt_d = rr_inc;
          end
        end
        default: state_d = ST_WARMUP;
      endcase
    end
  end

  // Running mean: the newest interval replaces the oldest in the ring.
  always_comb begin
    buf_d       = buf_q;
    wr_ptr_d    = wr_ptr_q;
    avg_cnt_d   = avg_cnt_q;
    acc_d       = acc_q;
    avg_valid_d = avg_valid_q;
    if (push_q) begin
      buf_d[wr_ptr_q] = rr_interval_q;
      acc_d    = acc_q + {{AVG_SH{1'b0}}, rr_interval_q} - {{AVG_SH{1'b0}}, buf_q[wr_ptr_q]};
      wr_ptr_d = wr_ptr_q + AVG_SH'(1);
      if (avg_cnt_q != AVG_FULL) begin
        avg_cnt_d = avg_cnt_q + CNT_W'(1);
      end
      if (avg_cnt_q == AVG_LAST) begin
        avg_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_WARMUP;
      s2_q          <= '0;
      s1_q          <= '0;
      fill_q        <= '0;
      rr_cnt_q      <= '0;
      refr_cnt_q    <= '0;
      peak_q        <= 1'b0;
      rr_interval_q <= '0;
      rr_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      push_q        <= 1'b0;
      wr_ptr_q      <= '0;
      avg_cnt_q     <= '0;
      acc_q         <= '0;
      avg_valid_q   <= 1'b0;
      for (int i = 0; i < AVG_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      s2_q          <= s2_d;
      s1_q          <= s1_d;
      fill_q        <= fill_d;
      rr_cnt_q      <= rr_cnt_d;
      refr_cnt_q    <= refr_cnt_d;
      peak_q        <= peak_d;
      rr_interval_q <= rr_interval_d;
      rr_valid_q    <= rr_valid_d;
      overrun_q     <= overrun_d;
      push_q        <= push_d;
      wr_ptr_q      <= wr_ptr_d;
      avg_cnt_q     <= avg_cnt_d;
      acc_q         <= acc_d;
      avg_valid_q   <= avg_valid_d;
      for (int i = 0; i < AVG_DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign peak_detected = peak_q;
  assign rr_interval   = rr_interval_q;
  assign rr_valid      = rr_valid_q;
  assign rr_avg        = acc_q[ACC_W-1:AVG_SH];
  assign avg_valid     = avg_valid_q;
  assign overrun       = overrun_q;
  assign asystole      = (state_q != ST_WARMUP) && (rr_cnt_q == RR_MAX);

endmodule
